mem_responder: RTL and testbench

Multi-cycle word memory that services the processor's load/store port, replacing the single-cycle data memory. It accepts one request per cycle over a valid/ready handshake. Writes commit on acceptance. Read data returns in order after a fixed `LATENCY` cycles. A build-time switch selects between a pipelined mode (one request per cycle) and a blocking mode (one read outstanding), so the same array can back either the single-cycle or the pipelined core.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_delay_line.sv | 40 ++++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Purpose: shared constants and FSM state type for the load/store word memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_LATENCY = 4;

  // Blocking-mode sequencer: IDLE accepts anything, WAIT counts down one read.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsmState_e;

endpackage

// File: rtl/mem_delay_line.sv
// Purpose: DEPTH-stage valid+data shift register carrying captured read words.
// Latency: DEPTH cycles from inVld/inDat to outVld/outDat.
// Backpressure: none; advances every cycle, the consumer must always take it.
module mem_delay_line
  import mem_pkg::*;
#(
  parameter int DEPTH  = MEM_LATENCY - 1,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inVld,
  input  logic [DATA_W-1:0] inDat,
  output logic              outVld,
  output logic [DATA_W-1:0] outDat
);

  logic [DEPTH-1:0]  vldSr;
  logic [DATA_W-1:0] datSr [DEPTH];

  // Valid bits are reset so reads in flight are dropped when reset hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldSr <= '0;
    end else begin
      vldSr[0] <= inVld;
      for (int i = 1; i < DEPTH; i++) vldSr[i] <= vldSr[i-1];
    end
  end

  // Data stages carry no reset; they are only meaningful alongside a valid bit.
  always_ff @(posedge clk) begin
    datSr[0] <= inDat;
    for (int i = 1; i < DEPTH; i++) datSr[i] <= datSr[i-1];
  end

  assign outVld = vldSr[DEPTH-1];
  assign outDat = datSr[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Purpose: multi-cycle word memory serving the core's load/store port.
// Latency: read data registered LATENCY edges after acceptance; writes commit on acceptance.
// Backpressure: pipelined never stalls; blocking holds req_ready low until the read's response cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = MEM_LATENCY,
  parameter int PIPELINED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = 4;

  logic [DATA_W-1:0] memArray [MEM_WORDS];
  logic [IDX_W-1:0]  wordIdx;
  logic              accept;
  logic              rdAccept;
  logic              wrAccept;
  logic [DATA_W-1:0] rdWord;
  logic              outOfReset;
  logic              readyRaw;
  logic              srcVld;
  logic [DATA_W-1:0] srcDat;
  logic              rspValidQ;
  logic [DATA_W-1:0] rspRdataQ;

  // Byte address -> word index; bit 0 and bits above the array size are dropped.
  assign wordIdx  = req_addr[IDX_W:1];
  assign accept   = req_valid & req_ready;
  assign rdAccept = accept & ~req_wr;
  assign wrAccept = accept & req_wr;
  assign rdWord   = memArray[wordIdx];
  assign req_ready = outOfReset & readyRaw;

  generate
    if (IDX_W + 1 < ADDR_W) begin : gUnusedHi
      logic unusedAddr;
      assign unusedAddr = ^{req_addr[ADDR_W-1:IDX_W+1], req_addr[0]};
    end else begin : gUnusedLo
      logic unusedAddr;
      assign unusedAddr = req_addr[0];
    end
  endgenerate

  // Array is never reset so a preloaded image survives reset.
  always_ff @(posedge clk) begin
    if (wrAccept) memArray[wordIdx] <= req_wdata;
  end

  // Ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outOfReset <= 1'b0;
    else        outOfReset <= 1'b1;
  end

  generate
    if (PIPELINED != 0) begin : gPipe
      assign readyRaw = 1'b1;
      if (LATENCY > 1) begin : gLine
        // The output register is the final stage, so the line is one shorter.
        mem_delay_line #(
          .DEPTH  (LATENCY - 1),
          .DATA_W (DATA_W)
        ) uDelay (
          .clk    (clk),
          .rst_n  (rst_n),
          .inVld  (rdAccept),
          .inDat  (rdWord),
          .outVld (srcVld),
          .outDat (srcDat)
        );
      end else begin : gDirect
        assign srcVld = rdAccept;
        assign srcDat = rdWord;
      end
    end else begin : gBlocking
      fsmState_e         state;
      fsmState_e         stateNxt;
      logic [CNT_W-1:0]  cnt;
      logic [CNT_W-1:0]  cntNxt;
      logic [DATA_W-1:0] holdDat;

      // The response cycle (cnt == 0) already accepts the next request, so
      // back-to-back reads land exactly LATENCY cycles apart.
      assign readyRaw = (state == IDLE) || (cnt == '0);

      // State and countdown registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= stateNxt;
          cnt   <= cntNxt;
        end
      end

      // Single holding register for the one outstanding read.
      always_ff @(posedge clk) begin
        if (rdAccept) holdDat <= rdWord;
      end

      // Next state, countdown, and one-cycle-early launch into the output register.
      always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        srcVld   = 1'b0;
        srcDat   = holdDat;
        if (rdAccept) begin
          stateNxt = WAIT;
          cntNxt   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            srcVld = 1'b1;
            srcDat = rdWord;
          end
        end else if (state == WAIT) begin
          if (cnt == '0) stateNxt = IDLE;
          else           cntNxt   = cnt - 1'b1;
          if (cnt == CNT_W'(1)) srcVld = 1'b1;
        end
      end
    end
  endgenerate

  // Registered response; data holds its last value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValidQ <= 1'b0;
      rspRdataQ <= '0;
    end else begin
      rspValidQ <= srcVld;
      if (srcVld) rspRdataQ <= srcDat;
    end
  end

  assign rsp_valid = rspValidQ;
  assign rsp_rdata = rspRdataQ;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: pipelined instance, index 1: blocking instance.
  logic [1:0]       rv, rw, rdy, rspV;
  logic [1:0][15:0] ra, wd, rspD;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(WORDS), .LATENCY(LAT), .PIPELINED(1)) dutP (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]), .rsp_valid(rspV[0]), .rsp_rdata(rspD[0]));

  mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(WORDS), .LATENCY(LAT), .PIPELINED(0)) dutB (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]), .rsp_valid(rspV[1]), .rsp_rdata(rspD[1]));

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] dat;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] mm [int];
  int          cycle = 0;
  bit          outOfRst = 1'b0;
  logic [15:0] lastD [2];
  bit          accL [2];
  bit          accW [2];
  logic [15:0] accA [2];
  logic [15:0] accD [2];
  int          lastAcc [2];

  int          gotC [8];
  logic [15:0] gotD [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int keyOf(input int i, input logic [15:0] a);
    return i * 4096 + ((int'(a) >> 1) % WORDS);
  endfunction

  function automatic int frontOf(input int i);
    for (int k = 0; k < pend.size(); k++)
      if (pend[k].inst == i) return k;
    return -1;
  endfunction

  // Commit accepted requests to the model at each edge.
  always @(posedge clk) begin
    cycle++;
    if (rst_n) begin
      outOfRst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (accL[i]) begin
          if (accW[i]) begin
            mm[keyOf(i, accA[i])] = accD[i];
          end else begin
            pend_t p;
            p.inst = i;
            p.due  = cycle + LAT - 1;
            p.dat  = mm[keyOf(i, accA[i])];
            pend.push_back(p);
          end
          lastAcc[i] = cycle;
        end
      end
    end
    accL[0] = 1'b0;
    accL[1] = 1'b0;
  end

  // Compare every cycle and latch what the coming edge will accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      outOfRst = 1'b0;
      pend.delete();
      for (int i = 0; i < 2; i++) begin
        lastD[i] = 16'h0;
        accL[i]  = 1'b0;
        chk(i == 0 ? "pipe_rst_ready" : "blk_rst_ready", {31'd0, rdy[i]}, 32'd0);
        chk(i == 0 ? "pipe_rst_valid" : "blk_rst_valid", {31'd0, rspV[i]}, 32'd0);
        chk(i == 0 ? "pipe_rst_rdata" : "blk_rst_rdata", {16'd0, rspD[i]}, 32'd0);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int f;
        int f2;
        bit expRdy;
        bit expV;
        f = frontOf(i);
        expV = (f >= 0) && (pend[f].due == cycle);
        expRdy = outOfRst && ((i == 0) || (f < 0) || expV);
        chk(i == 0 ? "pipe_ready" : "blk_ready", {31'd0, rdy[i]}, {31'd0, expRdy});
        chk(i == 0 ? "pipe_rsp_valid" : "blk_rsp_valid", {31'd0, rspV[i]}, {31'd0, expV});
        if (expV) begin
          chk(i == 0 ? "pipe_rsp_rdata" : "blk_rsp_rdata", {16'd0, rspD[i]}, {16'd0, pend[f].dat});
          lastD[i] = pend[f].dat;
          pend.delete(f);
        end else begin
          chk(i == 0 ? "pipe_rdata_hold" : "blk_rdata_hold", {16'd0, rspD[i]}, {16'd0, lastD[i]});
        end
        f2 = frontOf(i);
        if (f2 >= 0 && pend[f2].due < cycle) begin
          chk(i == 0 ? "pipe_missed_rsp" : "blk_missed_rsp", 32'(pend[f2].due), 32'(cycle));
          pend.delete(f2);
        end
        accL[i] = rv[i] && expRdy;
        accW[i] = rw[i];
        accA[i] = ra[i];
        accD[i] = wd[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int i, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, output int accEdge);
    rv[i] = 1'b1;
    rw[i] = wr;
    ra[i] = addr;
    wd[i] = data;
    accEdge = -1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      if (lastAcc[i] == cycle) begin
        accEdge = cycle;
        break;
      end
    end
    rv[i] = 1'b0;
    tests++;
    if (accEdge < 0) begin
      fails++;
      $display("FAIL accept_timeout: inst %0d addr 0x%0h never accepted", i, addr);
    end
  endtask

  task automatic collect(input int i, input int n, input int budget);
    int k;
    k = 0;
    for (int t = 0; t < budget && k < n; t++) begin
      @(negedge clk);
      if (rspV[i]) begin
        gotC[k] = cycle;
        gotD[k] = rspD[i];
        k++;
      end
    end
    tests++;
    if (k < n) begin
      fails++;
      $display("FAIL rsp_timeout: inst %0d got %0d responses, required %0d", i, k, n);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e, a, a1, a2, cntV;
    lastAcc[0] = -1;
    lastAcc[1] = -1;
    lastD[0] = 16'h0;
    lastD[1] = 16'h0;
    rv = '0; rw = '0; ra = '0; wd = '0;
    for (int k = 0; k < 8; k++) begin
      gotC[k] = -100;
      gotD[k] = 16'h0;
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release_pipe", {31'd0, rdy[0]}, 32'd1);
    chk("ready_after_release_blk",  {31'd0, rdy[1]}, 32'd1);

    // Write then read: response 4 edges after the read accept.
    issue(0, 1'b1, 16'h0010, 16'hBEEF, e);
    issue(0, 1'b0, 16'h0010, 16'h0000, a);
    collect(0, 1, 20);
    chk("t1_latency", 32'(gotC[0] - a + 1), 32'd4);
    chk("t1_data", {16'd0, gotD[0]}, 32'h0000BEEF);

    // Three back-to-back reads come back on consecutive cycles.
    issue(0, 1'b1, 16'h0000, 16'h1111, e);
    issue(0, 1'b1, 16'h0002, 16'h2222, e);
    issue(0, 1'b1, 16'h0004, 16'h3333, e);
    issue(0, 1'b0, 16'h0000, 16'h0000, a1);
    issue(0, 1'b0, 16'h0002, 16'h0000, a2);
    chk("t2_accept_spacing", 32'(a2 - a1), 32'd1);
    issue(0, 1'b0, 16'h0004, 16'h0000, e);
    collect(0, 3, 20);
    chk("t2_gap01", 32'(gotC[1] - gotC[0]), 32'd1);
    chk("t2_gap12", 32'(gotC[2] - gotC[1]), 32'd1);
    chk("t2_d0", {16'd0, gotD[0]}, 32'h00001111);
    chk("t2_d1", {16'd0, gotD[1]}, 32'h00002222);
    chk("t2_d2", {16'd0, gotD[2]}, 32'h00003333);

    // Write right after a read to the same word does not disturb that read.
    issue(0, 1'b1, 16'h0020, 16'hAAAA, e);
    issue(0, 1'b0, 16'h0020, 16'h0000, a);
    issue(0, 1'b1, 16'h0020, 16'h5555, e);
    collect(0, 1, 20);
    chk("t3_old_data", {16'd0, gotD[0]}, 32'h0000AAAA);
    issue(0, 1'b0, 16'h0020, 16'h0000, a);
    collect(0, 1, 20);
    chk("t3_new_data", {16'd0, gotD[0]}, 32'h00005555);

    // Blocking instance: second read waits, accepted on the first's response cycle.
    issue(1, 1'b1, 16'h0040, 16'h0A0A, e);
    issue(1, 1'b1, 16'h0042, 16'h0B0B, e);
    issue(1, 1'b0, 16'h0040, 16'h0000, a1);
    fork
      issue(1, 1'b0, 16'h0042, 16'h0000, a2);
      collect(1, 2, 40);
    join
    chk("t4_accept_spacing", 32'(a2 - a1), 32'd4);
    chk("t4_first_latency", 32'(gotC[0] - a1 + 1), 32'd4);
    chk("t4_accept_on_rsp", 32'(a2), 32'(gotC[0] + 1));
    chk("t4_rsp_spacing", 32'(gotC[1] - gotC[0]), 32'd4);
    chk("t4_d0", {16'd0, gotD[0]}, 32'h00000A0A);
    chk("t4_d1", {16'd0, gotD[1]}, 32'h00000B0B);

    // Address wrap modulo 1024 words; odd byte address maps to the same word.
    issue(0, 1'b1, 16'h0802, 16'h1234, e);
    issue(0, 1'b0, 16'h0002, 16'h0000, a);
    collect(0, 1, 20);
    chk("t5_wrap", {16'd0, gotD[0]}, 32'h00001234);
    issue(0, 1'b0, 16'h0003, 16'h0000, a);
    collect(0, 1, 20);
    chk("t5_odd", {16'd0, gotD[0]}, 32'h00001234);

    // Reset two cycles after a read accept drops that read.
    issue(0, 1'b0, 16'h0010, 16'h0000, a);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cntV = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rspV[0]) cntV++;
    end
    chk("t6_no_rsp", 32'(cntV), 32'd0);
    chk("t6_rdata_zero", {16'd0, rspD[0]}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 1'b0, 16'h0010, 16'h0000, a);
    collect(0, 1, 20);
    chk("t6_retained_pipe", {16'd0, gotD[0]}, 32'h0000BEEF);
    issue(1, 1'b0, 16'h0040, 16'h0000, a);
    collect(1, 1, 20);
    chk("t6_retained_blk", {16'd0, gotD[0]}, 32'h00000A0A);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
